// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the pratica2 control unit: opcodes, time-step
// encoding and instruction-register field positions.
package proc_ctrl_pkg;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam int unsigned IrW = 9;

    localparam int unsigned OpMsb = 8;
    localparam int unsigned OpLsb = 6;
    localparam int unsigned XMsb  = 5;
    localparam int unsigned XLsb  = 3;
    localparam int unsigned YMsb  = 2;
    localparam int unsigned YLsb  = 0;

    localparam logic [2:0] OpMv   = 3'b000;
    localparam logic [2:0] OpMvi  = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpSub  = 3'b011;
    localparam logic [2:0] OpMvnz = 3'b100;

    function automatic logic [2:0] ir_op(input logic [IrW-1:0] ir);
        return ir[OpMsb:OpLsb];
    endfunction

    function automatic logic [2:0] ir_x(input logic [IrW-1:0] ir);
        return ir[XMsb:XLsb];
    endfunction

    function automatic logic [2:0] ir_y(input logic [IrW-1:0] ir);
        return ir[YMsb:YLsb];
    endfunction

endpackage

// File: rtl/dec3to8.sv
// 3-to-8 one-hot decoder with enable; output is all zeros when disabled.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = 8'h00;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_ctrl_fsm.sv
// Time-step control unit for the pratica2 datapath: IR, T0-T3 sequencer,
// bus/load strobes and a completed-instruction counter.
// Optional feature: define PROC_MVNZ_EN to enable the mvnz opcode.
module proc_ctrl_fsm
    import proc_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic [8:0]             din_ir,
    input  logic                   g_nz,
    output logic                   ir_in,
    output logic [7:0]             r_in,
    output logic [7:0]             r_out,
    output logic                   g_out,
    output logic                   din_out,
    output logic                   a_in,
    output logic                   g_in,
    output logic                   add_sub,
    output logic                   done,
    output logic [8:0]             ir,
    output logic [1:0]             state,
    output logic [INSTR_CNT_W-1:0] instr_count
);

    state_t                 state_q;
    logic [IrW-1:0]         ir_q;
    logic [INSTR_CNT_W-1:0] cnt_q;

    logic [2:0] op;
    logic [2:0] x_idx;
    logic [2:0] y_idx;
    logic [2:0] rout_idx;
    logic       rin_en;
    logic       rout_en;
    logic       rout_sel_x;

    assign op    = ir_op(ir_q);
    assign x_idx = ir_x(ir_q);
    assign y_idx = ir_y(ir_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                T0: begin
                    if (run) begin
                        ir_q    <= din_ir;
                        state_q <= T1;
                    end
                end
                T1: state_q <= (op == OpAdd || op == OpSub) ? T2 : T0;
                T2: state_q <= T3;
                T3: state_q <= T0;
                default: state_q <= T0;
            endcase
            if (done) begin
                cnt_q <= cnt_q + INSTR_CNT_W'(1);
            end
        end
    end

    always_comb begin
        ir_in      = 1'b0;
        rin_en     = 1'b0;
        rout_en    = 1'b0;
        rout_sel_x = 1'b0;
        g_out      = 1'b0;
        din_out    = 1'b0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        add_sub    = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            // Gate with reset so a held run cannot leak a fetch strobe.
            T0: ir_in = run & ~reset;
            T1: begin
                case (op)
                    OpMv: begin
                        rout_en = 1'b1;
                        rin_en  = 1'b1;
                        done    = 1'b1;
                    end
                    OpMvi: begin
                        din_out = 1'b1;
                        rin_en  = 1'b1;
                        done    = 1'b1;
                    end
                    OpAdd, OpSub: begin
                        rout_en    = 1'b1;
                        rout_sel_x = 1'b1;
                        a_in       = 1'b1;
                    end
`ifdef PROC_MVNZ_EN
                    OpMvnz: begin
                        rout_en = g_nz;
                        rin_en  = g_nz;
                        done    = 1'b1;
                    end
`endif
                    default: done = 1'b1;
                endcase
            end
            T2: begin
                rout_en = 1'b1;
                g_in    = 1'b1;
                add_sub = (op == OpSub);
            end
            T3: begin
                g_out  = 1'b1;
                rin_en = 1'b1;
                done   = 1'b1;
            end
            default: ;
        endcase
    end

`ifndef PROC_MVNZ_EN
    logic unused_g_nz;
    assign unused_g_nz = g_nz;
`endif

    assign rout_idx = rout_sel_x ? x_idx : y_idx;

    dec3to8 u_dec_rin (
        .en     (rin_en),
        .sel    (x_idx),
        .onehot (r_in)
    );

    dec3to8 u_dec_rout (
        .en     (rout_en),
        .sel    (rout_idx),
        .onehot (r_out)
    );

    assign ir          = ir_q;
    assign state       = state_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// Bench for proc_ctrl_fsm: directed vector table, reset/abort sequences and
// randomized instructions against a step-list reference model.
module tb_proc_ctrl_fsm;

    localparam int unsigned CW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          run;
    logic [8:0]    din_ir;
    logic          g_nz;
    logic          ir_in;
    logic [7:0]    r_in;
    logic [7:0]    r_out;
    logic          g_out;
    logic          din_out;
    logic          a_in;
    logic          g_in;
    logic          add_sub;
    logic          done;
    logic [8:0]    ir;
    logic [1:0]    state;
    logic [CW-1:0] instr_count;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    proc_ctrl_fsm #(
        .INSTR_CNT_W (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .din_ir      (din_ir),
        .g_nz        (g_nz),
        .ir_in       (ir_in),
        .r_in        (r_in),
        .r_out       (r_out),
        .g_out       (g_out),
        .din_out     (din_out),
        .a_in        (a_in),
        .g_in        (g_in),
        .add_sub     (add_sub),
        .done        (done),
        .ir          (ir),
        .state       (state),
        .instr_count (instr_count)
    );

    // {ir_in, r_in, r_out, g_out, din_out, a_in, g_in, add_sub, done, state}
    function automatic logic [24:0] pk(input logic i, input logic [7:0] ri,
                                       input logic [7:0] ro, input logic go,
                                       input logic dout, input logic ai,
                                       input logic gi, input logic as,
                                       input logic dn, input logic [1:0] st);
        return {i, ri, ro, go, dout, ai, gi, as, dn, st};
    endfunction

    function automatic logic [24:0] act_vec();
        return {ir_in, r_in, r_out, g_out, din_out, a_in, g_in, add_sub, done, state};
    endfunction

    function automatic logic [7:0] oh(input logic [2:0] idx);
        logic [7:0] v;
        v = 8'h01;
        return v << idx;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic chk_all(input string tag, input logic [24:0] e, input logic [8:0] eir,
                           input logic [CW-1:0] ecnt);
        chk({tag, "_strobes"}, 32'(act_vec()), 32'(e));
        chk({tag, "_ir"}, 32'(ir), 32'(eir));
        chk({tag, "_count"}, 32'(instr_count), 32'(ecnt));
    endtask

    // Reference model: each fetched instruction becomes a list of per-step outputs.
    logic [24:0]   exp_q[$];
    logic [8:0]    m_ir;
    logic [CW-1:0] m_cnt;

    task automatic push_instr(input logic [8:0] w, input logic g);
        logic [2:0] op;
        logic [2:0] x;
        logic [2:0] y;
        op = w[8:6];
        x  = w[5:3];
        y  = w[2:0];
        if (op == 3'd0) begin
            exp_q.push_back(pk(1'b0, oh(x), oh(y), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1));
        end else if (op == 3'd1) begin
            exp_q.push_back(pk(1'b0, oh(x), 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1));
        end else if (op == 3'd2 || op == 3'd3) begin
            exp_q.push_back(pk(1'b0, 8'h00, oh(x), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1));
            exp_q.push_back(pk(1'b0, 8'h00, oh(y), 1'b0, 1'b0, 1'b0, 1'b1, op == 3'd3,
                               1'b0, 2'd2));
            exp_q.push_back(pk(1'b0, oh(x), 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3));
`ifdef PROC_MVNZ_EN
        end else if (op == 3'd4 && g) begin
            exp_q.push_back(pk(1'b0, oh(x), oh(y), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1));
`endif
        end else begin
            exp_q.push_back(pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1));
        end
    endtask

    task automatic model_edge();
        logic [24:0] v;
        if (exp_q.size() != 0) begin
            v = exp_q.pop_front();
            if (v[2]) m_cnt = m_cnt + 1'b1;
        end else if (run) begin
            m_ir = din_ir;
            push_instr(din_ir, g_nz);
        end
    endtask

    typedef struct {
        logic          run;
        logic [8:0]    din;
        logic          gnz;
        logic [24:0]   exp;
        logic [8:0]    eir;
        logic [CW-1:0] ecnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [8:0] d, input logic g,
                                input logic [24:0] e, input logic [8:0] eir, input int c);
        vec_t v;
        v.run  = r;
        v.din  = d;
        v.gnz  = g;
        v.exp  = e;
        v.eir  = eir;
        v.ecnt = c[CW-1:0];
        return v;
    endfunction

    vec_t tbl[20];
    logic [24:0] idle0;
    logic [24:0] fetch;
    logic [24:0] only_done;

    initial begin
        idle0     = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        fetch     = pk(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        only_done = pk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1);

        // mvi R0; mv R1,R0; add R0,R1 (run dropped mid-op); sub R0,R1; mvnz; undefined
        tbl[0]  = mk(1'b1, 9'h040, 1'b0, fetch, 9'h000, 0);
        tbl[1]  = mk(1'b1, 9'h008, 1'b0,
                     pk(1'b0, 8'h01, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1), 9'h040, 0);
        tbl[2]  = mk(1'b1, 9'h008, 1'b0, fetch, 9'h040, 1);
        tbl[3]  = mk(1'b1, 9'h081, 1'b0,
                     pk(1'b0, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1), 9'h008, 1);
        tbl[4]  = mk(1'b1, 9'h081, 1'b0, fetch, 9'h008, 2);
        tbl[5]  = mk(1'b0, 9'h000, 1'b0,
                     pk(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1), 9'h081, 2);
        tbl[6]  = mk(1'b0, 9'h000, 1'b0,
                     pk(1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2), 9'h081, 2);
        tbl[7]  = mk(1'b0, 9'h000, 1'b0,
                     pk(1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3), 9'h081, 2);
        tbl[8]  = mk(1'b1, 9'h0C1, 1'b0, fetch, 9'h081, 3);
        tbl[9]  = mk(1'b1, 9'h0C1, 1'b0,
                     pk(1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1), 9'h0C1, 3);
        tbl[10] = mk(1'b1, 9'h0C1, 1'b0,
                     pk(1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2), 9'h0C1, 3);
        tbl[11] = mk(1'b1, 9'h0C1, 1'b0,
                     pk(1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3), 9'h0C1, 3);
        tbl[12] = mk(1'b0, 9'h115, 1'b1, idle0, 9'h0C1, 4);
        tbl[13] = mk(1'b1, 9'h115, 1'b1, fetch, 9'h0C1, 4);
`ifdef PROC_MVNZ_EN
        tbl[14] = mk(1'b1, 9'h115, 1'b1,
                     pk(1'b0, 8'h04, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1), 9'h115, 4);
`else
        tbl[14] = mk(1'b1, 9'h115, 1'b1, only_done, 9'h115, 4);
`endif
        tbl[15] = mk(1'b1, 9'h115, 1'b0, fetch, 9'h115, 5);
        tbl[16] = mk(1'b1, 9'h1C0, 1'b0, only_done, 9'h115, 5);
        tbl[17] = mk(1'b1, 9'h1C0, 1'b0, fetch, 9'h115, 6);
        tbl[18] = mk(1'b0, 9'h000, 1'b0, only_done, 9'h1C0, 6);
        tbl[19] = mk(1'b0, 9'h000, 1'b0, idle0, 9'h1C0, 7);

        // Reset held with run high: nothing may strobe.
        reset  = 1'b1;
        run    = 1'b1;
        din_ir = 9'h0FB;
        g_nz   = 1'b0;
        #3;
        chk_all("reset", idle0, 9'h000, '0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #3;
        chk_all("first_fetch", fetch, 9'h000, '0);

        // sub R7,R3 aborted by reset during T2.
        @(posedge clock);
        #1;
        run = 1'b0;
        #3;
        chk_all("abort_t1", pk(1'b0, 8'h00, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1),
                9'h0FB, '0);
        @(posedge clock);
        #4;
        chk_all("abort_t2", pk(1'b0, 8'h00, 8'h08, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd2),
                9'h0FB, '0);
        #1;
        reset = 1'b1;
        run   = 1'b1;
        #1;
        chk_all("abort_now", idle0, 9'h000, '0);
        @(posedge clock);
        #1;
        chk_all("abort_held", idle0, 9'h000, '0);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run    = tbl[i].run;
            din_ir = tbl[i].din;
            g_nz   = tbl[i].gnz;
            #3;
            chk_all($sformatf("vec%0d", i), tbl[i].exp, tbl[i].eir, tbl[i].ecnt);
            @(posedge clock);
            #1;
        end

        reset = 1'b1;
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_ir  = '0;
        m_cnt = '0;
        for (int c = 0; c < 600; c++) begin
            logic [24:0] e;
            run = ($urandom_range(0, 3) != 0);
            if (exp_q.size() == 0) begin
                din_ir = 9'($urandom_range(0, 511));
                g_nz   = 1'($urandom_range(0, 1));
            end
            #3;
            e = (exp_q.size() != 0) ? exp_q[0] : (run ? fetch : idle0);
            chk_all("rand", e, m_ir, m_cnt);
            model_edge();
            @(posedge clock);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/proc_ctrl_fsm.md
# proc_ctrl_fsm

Control unit for the pratica2 processor datapath, which has R0–R7, A, G, an add/sub unit and a shared 16-bit bus. It owns the 9-bit instruction register and a time-step state machine. Each clock it drives the register-load, bus-select and ALU strobes that sequence one instruction. It also counts completed instructions. It sits between the datapath and its external run/din sources.

## Interface
- `INSTR_CNT_W`, default 16: width of the completed-instruction counter.
- `clock`, input, 1: system clock; all state changes on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `run`, input, 1: start request; sampled only in state T0.
- `din_ir`, input, 9: instruction word from `din[15:7]`, formatted as opcode III, operand XXX, operand YYY.
- `g_nz`, input, 1: G register nonzero flag from the datapath. Used only when `PROC_MVNZ_EN` is defined.
- `ir_in`, output, 1: instruction register load strobe.
- `r_in`, output, 8: one-hot register load enables for R0–R7.
- `r_out`, output, 8: one-hot register-to-bus enables.
- `g_out`, output, 1: drives G onto the bus.
- `din_out`, output, 1: drives `din` onto the bus.
- `a_in`, output, 1: loads the A register.
- `g_in`, output, 1: loads the G register.
- `add_sub`, output, 1: ALU operation select; 0 means add, 1 means subtract.
- `done`, output, 1: one-cycle pulse in the final step of an instruction.
- `ir`, output, 9: current instruction register contents.
- `state`, output, 2: current time step for debug; T0=0, T1=1, T2=2, T3=3.
- `instr_count`, output, `INSTR_CNT_W`: number of `done` pulses since reset.

## Operation
- Opcodes: 000 mv Rx,Ry; 001 mvi Rx,#D; 010 add Rx,Ry; 011 sub Rx,Ry; 100 mvnz Rx,Ry (macro only). Every other opcode is undefined.
- T0:
  - `ir_in` = `run`.
  - If `run` is high, IR loads `din_ir` and the state goes to T1; otherwise the state stays in T0.
- T1, by opcode:
  - mv: `r_out[Y]`, `r_in[X]`, `done`; then T0.
  - mvi: `din_out`, `r_in[X]`, `done`; then T0. The immediate is the `din` value present during T1.
  - add/sub: `r_out[X]`, `a_in`; then T2.
  - Undefined opcode: `done` only, no other strobes; then T0.
- T2: `r_out[Y]`, `g_in`, `add_sub` = (opcode == sub); then T3.
- T3: `g_out`, `r_in[X]`, `done`; then T0.
- All strobes are combinational from state and IR. The one exception is `ir_in`, which also depends on `run`.
- Bus rule: at most one of `r_out` bits, `g_out` and `din_out` is high in any cycle. `r_in` and `r_out` are always one-hot or zero.
- `run` falling mid-instruction has no effect; the instruction always completes.
- `instr_count` increments on every clock edge where `done` is high. It wraps from all-ones to 0.
- X == Y is legal. For example, mv R3,R3 and add R2,R2 simply use the same index for both strobes.

## Timing
- Reset (asynchronous, active-high) forces:
  - state = T0, `ir` = 0, `instr_count` = 0.
  - All strobes 0 while `reset` is high, including `ir_in` regardless of `run`.
- Reset asserted mid-instruction aborts immediately. No `done` pulse, and the counter does not change.
- Latency from the fetch edge, counting T0 through the final step:
  - mv, mvi, undefined and mvnz: 2 cycles.
  - add and sub: 4 cycles.
- With `run` held high, instructions issue back-to-back: T0 follows the `done` cycle directly.

## Configuration
- `PROC_MVNZ_EN` defined: opcode 100 means mvnz.
  - In T1, if `g_nz` is 1, drive `r_out[Y]` and `r_in[X]`.
  - `done` is asserted in T1 in both cases, then the state returns to T0.
- `PROC_MVNZ_EN` undefined: opcode 100 is an undefined opcode, and `g_nz` is ignored.

## Structure
- Package `proc_ctrl_pkg` holds:
  - Opcode constants.
  - The 2-bit state typedef (T0–T3).
  - IR field positions: opcode [8:6], X [5:3], Y [2:0].
- Sub-module `dec3to8` is a 3-to-8 one-hot decoder with an enable input. It is instantiated for the X and Y fields.

## Test plan
- Reset with `run` = 1: all strobes 0, `state` = 0, `ir` = 0, `instr_count` = 0. After reset release, the first edge gives `ir_in` = 1.
- mvi R0,#2 (`din_ir` = 9'b001_000_000, `din` = 2): T1 has `din_out` = 1, `r_in` = 8'h01, `done` = 1. `instr_count` then goes 0→1.
- mv R1,R0 (9'b000_001_000): T1 has `r_out` = 8'h01, `r_in` = 8'h02, `done` = 1. Back-to-back with `run` held high, the next T0 follows directly.
- add R0,R1 (9'b010_000_001):
  - T1: `r_out` = 8'h01, `a_in` = 1.
  - T2: `r_out` = 8'h02, `g_in` = 1, `add_sub` = 0.
  - T3: `g_out` = 1, `r_in` = 8'h01, `done` = 1.
  - Repeat as sub (opcode 011) and check `add_sub` = 1 in T2.
- sub R7,R3 with `reset` pulsed during T2: `state` = 0 immediately, all strobes 0, no `done`, `instr_count` unchanged.
- Opcode 100, X=2, Y=5:
  - With the macro and `g_nz` = 0: only `done` is asserted.
  - With the macro and `g_nz` = 1: `r_out` = 8'h20 and `r_in` = 8'h04.
  - Without the macro: only `done` is asserted, whatever `g_nz` is.
